// File: rtl/remote_cmd_pkg.sv
// Shared types and constants for the remote-link command sequencer.
package remote_cmd_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SEND,
      WAIT_TX,
      WAIT_ACK
   } state_t;

   localparam logic [7:0] ACK_POS = 8'hA5;

endpackage

// File: rtl/cmd_fifo.sv
// Circular command queue with registered occupancy flags for the remote-link sequencer.
module cmd_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [WIDTH-1:0]         wdata,
   input  logic                     push,
   input  logic                     pop,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;
   logic [PW:0]      count_d;
   logic             wr_en;
   logic             rd_en;

   // A push against a full queue still lands when the head leaves on the same edge.
   assign rd_en = pop && !empty;
   assign wr_en = push && (!full || rd_en);
   assign rdata = mem[rd_ptr];

   always_comb begin
      count_d = count;
      if (wr_en && !rd_en)
         count_d = count + 1'b1;
      else if (rd_en && !wr_en)
         count_d = count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (wr_en)
         mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         full   <= 1'b0;
         empty  <= 1'b1;
      end else begin
         if (wr_en)
            wr_ptr <= wr_ptr + 1'b1;
         if (rd_en)
            rd_ptr <= rd_ptr + 1'b1;
         count <= count_d;
         full  <= (count_d == FULL_CNT);
         empty <= (count_d == '0);
      end
   end

endmodule

// File: rtl/remote_cmd_seq.sv
// Queued multi-byte command sender for the remote link: serialises MSB byte first,
// waits for the positive acknowledge and retransmits on timeout or wrong response.
module remote_cmd_seq
   import remote_cmd_pkg::*;
#(
   parameter int CMD_BYTES = 2,
   parameter int DEPTH     = 4,
   parameter int TIMEOUT   = 2000000,
   parameter int MAX_RETRY = 2
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [8*CMD_BYTES-1:0]   cmd_in,
   input  logic                     push,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count,
   output logic [7:0]               tx_data,
   output logic                     trmt,
   input  logic                     tx_done,
   input  logic [7:0]               rx_data,
   input  logic                     rx_rdy,
   output logic [7:0]               resp,
   output logic                     busy,
   output logic                     cmd_done,
   output logic                     cmd_err
);

   localparam int CW = 8*CMD_BYTES;
   localparam int BW = (CMD_BYTES > 1) ? $clog2(CMD_BYTES) : 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY+1) : 1;
   localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [BW-1:0] LAST_BYTE = BW'(CMD_BYTES-1);
   localparam logic [RW-1:0] RETRY_LIM = RW'(MAX_RETRY);
   localparam logic [TW-1:0] TIME_LIM  = TW'(TIMEOUT-1);

   state_t          state_q, state_d;
   logic [CW-1:0]   cmd_q, cmd_d;
   logic [BW-1:0]   byte_idx_q, byte_idx_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [TW-1:0]   timer_q, timer_d;
   logic [7:0]      tx_data_d;
   logic            trmt_d;
   logic            done_d;
   logic            err_d;
   logic            pop;
   logic [CW-1:0]   head;

   cmd_fifo #(
      .WIDTH (CW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .wdata (cmd_in),
      .push  (push),
      .pop   (pop),
      .rdata (head),
      .full  (full),
      .empty (empty),
      .count (count)
   );

   assign busy = (state_q != IDLE);

   always_comb begin
      state_d    = state_q;
      cmd_d      = cmd_q;
      byte_idx_d = byte_idx_q;
      retry_d    = retry_q;
      timer_d    = timer_q;
      tx_data_d  = tx_data;
      trmt_d     = 1'b0;
      done_d     = 1'b0;
      err_d      = 1'b0;
      pop        = 1'b0;
      case (state_q)
         IDLE: begin
            if (!empty) begin
               pop        = 1'b1;
               cmd_d      = head;
               byte_idx_d = '0;
               retry_d    = '0;
               state_d    = SEND;
            end
         end
         SEND: begin
            tx_data_d = 8'(cmd_q >> (8*(CMD_BYTES-1-int'(byte_idx_q))));
            trmt_d    = 1'b1;
            state_d   = WAIT_TX;
         end
         WAIT_TX: begin
            if (tx_done) begin
               if (byte_idx_q == LAST_BYTE) begin
                  timer_d = '0;
                  state_d = WAIT_ACK;
               end else begin
                  byte_idx_d = byte_idx_q + 1'b1;
                  state_d    = SEND;
               end
            end
         end
         WAIT_ACK: begin
            if (timer_q != '1)
               timer_d = timer_q + 1'b1;
            // A response arriving on the expiry cycle wins over the timeout.
            if (rx_rdy && (rx_data == ACK_POS)) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end else if (rx_rdy || (timer_q == TIME_LIM)) begin
               if (retry_q < RETRY_LIM) begin
                  retry_d    = retry_q + 1'b1;
                  byte_idx_d = '0;
                  state_d    = SEND;
               end else begin
                  err_d   = 1'b1;
                  state_d = IDLE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         cmd_q      <= '0;
         byte_idx_q <= '0;
         retry_q    <= '0;
         timer_q    <= '0;
         tx_data    <= '0;
         trmt       <= 1'b0;
         cmd_done   <= 1'b0;
         cmd_err    <= 1'b0;
         resp       <= '0;
      end else begin
         state_q    <= state_d;
         cmd_q      <= cmd_d;
         byte_idx_q <= byte_idx_d;
         retry_q    <= retry_d;
         timer_q    <= timer_d;
         tx_data    <= tx_data_d;
         trmt       <= trmt_d;
         cmd_done   <= done_d;
         cmd_err    <= err_d;
         if (rx_rdy)
            resp <= rx_data;
      end
   end

endmodule
